cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 exception endpoint. It consumes the exception tags (EXcode, delay slot flag, PC) that the pipeline registers carry, and produces the flush/redirect request `req` those registers act on.
- Sits beside the M stage. It holds SR, Cause, EPC and PRId, and serves the mfc0, mtc0 and eret instructions.

Parameters:
- PRID_VALUE, 32'h2021_0B0A, read-only contents of PRId (reg 15).
- HWINT_W, 6, number of hardware interrupt lines; maps to SR.IM and Cause.IP bits [15:10].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- EXLClr  in  1  eret in M stage; clears SR.EXL.
- pc_in  in  32  PC of the M-stage instruction.
- EXcode_in  in  5  exception code tagged on the M-stage instruction; 0 = none.
- delay_in  in  1  M-stage instruction is in a branch delay slot.
- HWInt  in  HWINT_W  hardware interrupt levels.
- DOut  out  32  mfc0 read data.
- EPC_out  out  32  eret target.
- req  out  1  take exception/interrupt this cycle (combinational).

Behaviour:
- Register fields:
  - SR: IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause: BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
- Reset (async, reset=0): SR=0, Cause=0, EPC=0.
  - Resulting outputs: DOut=0 for A1≠15, DOut=PRID_VALUE for A1=15, EPC_out=0, and req=0 provided EXcode_in=0.
- Request logic (combinational):
  - int_req = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
  - exc_req = (EXcode_in≠0) & ~SR.EXL.
  - req = int_req | exc_req.
  - Interrupt has priority over exception.
- Every posedge, Cause.IP <= HWInt, whether or not req is asserted.
- Posedge with req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : EXcode_in.
  - Cause.BD <= delay_in.
  - EPC <= delay_in ? pc_in−4 : pc_in, with bits [1:0] forced to 0.
- Posedge with req=0 and WE=1, by A2:
  - 12: SR <= DIn masked to implemented fields.
  - 14: EPC <= {DIn[31:2], 2'b00}.
  - 13 and 15 are read-only; writes are ignored.
  - Any other address: write ignored.
- Posedge with req=0 and EXLClr=1: SR.EXL <= 0.
  - If WE to SR occurs in the same cycle, the mtc0 value is written first, then EXL is cleared.
- Simultaneous events:
  - req wins over WE: the write is dropped.
  - req wins over EXLClr: EXL stays 1.
- Reads: DOut is combinational from A1 over the current registers.
  - 12 returns SR, 13 returns Cause, 14 returns EPC, 15 returns PRID_VALUE.
  - Any other address returns 0.
  - No write-through within a cycle (except EPC_out under the optional feature below).
- EPC_out = EPC register.
- Exception handling is one-deep: while EXL=1, no new req is raised. Nesting is not supported.
- Reset asserted mid-exception clears EXL and EPC immediately, without waiting for clk.
- pc_in−4 wraps modulo 2^32.

Optional Feature:
- Macro CP0_EPC_FWD_EN.
- Defined: when WE=1, A2=14 and req=0, EPC_out = {DIn[31:2], 2'b00} in the same cycle. This covers an mtc0 EPC immediately followed by an eret.
- Undefined: EPC_out is always the registered EPC; software must separate mtc0 EPC and eret by one instruction.

Decomposition:
- Package cp0_pkg:
  - Register number constants: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - EXcode constants: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
  - Field bit positions: IM, EXL, IE, BD, IP, ExcCode.
- One sub-module is natural: cp0_req_gen. It is purely combinational and computes int_req, exc_req, req and the ExcCode to record. It is kept separate so the hazard/flush logic can be verified on it in isolation.

Test Plan:
1. Reset, then A1=15 -> DOut=PRID_VALUE. A1=12/13/14 -> 0. req=0.
2. mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 -> req=1 in the same cycle. Next cycle: EXL=1, ExcCode=0, EPC=pc_in, req=0.
3. EXcode_in=12 (Ov), delay_in=1, pc_in=32'h0000_3010 -> req=1. Next cycle: Cause.BD=1, ExcCode=12, EPC=32'h0000_300C.
4. Interrupt and EXcode_in=4 in the same cycle -> ExcCode recorded 0. Then WE=1 with A2=12 in the same cycle as req -> SR unchanged.
5. With EXL=1, EXcode_in=10 -> req=0. EXLClr=1 -> EXL=0 next cycle, and req rises if EXcode_in is still 10.
6. mtc0 EPC=32'h0000_3003 -> EPC reads 32'h0000_3000. With CP0_EPC_FWD_EN: EPC_out=32'h0000_3000 in the same cycle. Without it: one cycle later.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, exception codes, field positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes carried down the pipeline (0 doubles as "no exception")
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // SR field positions
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Cause field positions
  localparam int BD_BIT     = 31;
  localparam int IP_LO      = 10;
  localparam int EXCCODE_LO = 2;

endpackage

// File: rtl/cp0_req_gen.sv
// Exception/interrupt request decode and the ExcCode to record on a take.
// Latency: purely combinational.
// Backpressure: none; EXL=1 suppresses every new request (one-deep handling).
module cp0_req_gen #(
  parameter int HWINT_W = 6
) (
  input  logic [HWINT_W-1:0] hwint,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  input  logic [4:0]         excode,
  output logic               int_req,
  output logic               exc_req,
  output logic               req,
  output logic [4:0]         rec_code
);
  import cp0_pkg::*;

  // Interrupt beats a synchronous exception; recorded code follows the winner
  always_comb begin
    int_req  = (|(hwint & im)) & ie & ~exl;
    exc_req  = (excode != EXC_INT) & ~exl;
    req      = int_req | exc_req;
    rec_code = int_req ? EXC_INT : excode;
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 endpoint: SR/Cause/EPC/PRId, mfc0/mtc0/eret and flush request.
// Latency: req and DOut combinational; register updates land on the next posedge.
// Backpressure: none; req overrides a same-cycle mtc0 and eret. Build option CP0_EPC_FWD_EN.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2021_0B0A,
  parameter int          HWINT_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic               EXLClr,
  input  logic [31:0]        pc_in,
  input  logic [4:0]         EXcode_in,
  input  logic               delay_in,
  input  logic [HWINT_W-1:0] HWInt,
  output logic [31:0]        DOut,
  output logic [31:0]        EPC_out,
  output logic               req
);
  import cp0_pkg::*;

  logic [HWINT_W-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [HWINT_W-1:0] cause_ip;
  logic [4:0]         cause_exc;
  logic [31:0]        epc;

  logic               int_req;
  logic               exc_req;
  logic [4:0]         rec_code;
  logic [31:0]        epc_take;
  logic [31:0]        sr_word;
  logic [31:0]        cause_word;
  logic               unused_req_split;

  cp0_req_gen #(.HWINT_W(HWINT_W)) u_req_gen (
    .hwint    (HWInt),
    .im       (sr_im),
    .ie       (sr_ie),
    .exl      (sr_exl),
    .excode   (EXcode_in),
    .int_req  (int_req),
    .exc_req  (exc_req),
    .req      (req),
    .rec_code (rec_code)
  );

  // The individual request terms are only needed for isolated checking of the sub-block
  assign unused_req_split = int_req ^ exc_req;

  // Restart PC: a delay-slot victim restarts at its branch; subtraction wraps naturally
  always_comb begin
    epc_take       = delay_in ? (pc_in - 32'd4) : pc_in;
    epc_take[1:0]  = 2'b00;
  end

  // Register file: exception take dominates, then mtc0, then eret clears EXL last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= rec_code;
        cause_bd  <= delay_in;
        epc       <= epc_take;
      end else begin
        if (WE && (A2 == CP0_SR)) begin
          sr_im  <= DIn[IM_LO +: HWINT_W];
          sr_exl <= DIn[EXL_BIT];
          sr_ie  <= DIn[IE_BIT];
        end
        if (WE && (A2 == CP0_EPC)) begin
          epc <= {DIn[31:2], 2'b00};
        end
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // Assemble architectural views; unimplemented bits read as zero
  always_comb begin
    sr_word                            = '0;
    sr_word[IM_LO +: HWINT_W]          = sr_im;
    sr_word[EXL_BIT]                   = sr_exl;
    sr_word[IE_BIT]                    = sr_ie;
    cause_word                         = '0;
    cause_word[BD_BIT]                 = cause_bd;
    cause_word[IP_LO +: HWINT_W]       = cause_ip;
    cause_word[EXCCODE_LO +: 5]        = cause_exc;
  end

  // mfc0 read mux over current register contents
  always_comb begin
    DOut = '0;
    case (A1)
      CP0_SR:    DOut = sr_word;
      CP0_CAUSE: DOut = cause_word;
      CP0_EPC:   DOut = epc;
      CP0_PRID:  DOut = PRID_VALUE;
      default:   DOut = '0;
    endcase
  end

  // eret target; the forwarding build lets an mtc0 EPC feed an eret right behind it
`ifdef CP0_EPC_FWD_EN
  always_comb begin
    EPC_out = epc;
    if (WE && (A2 == CP0_EPC) && !req) begin
      EPC_out = {DIn[31:2], 2'b00};
    end
  end
`else
  always_comb begin
    EPC_out = epc;
  end
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: stimulus queues expectations, monitor checks them.
// Latency: checks sampled on the falling edge of the cycle the stimulus was applied.
// Backpressure: n/a.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2021_0B0A;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic [31:0] pc_in;
  logic [4:0]  EXcode_in;
  logic        delay_in;
  logic [5:0]  HWInt;
  logic [31:0] DOut;
  logic [31:0] EPC_out;
  logic        req;

  typedef struct {
    int          sel;   // 0 = DOut, 1 = EPC_out, 2 = req
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   fails  = 0;

  cp0_unit #(.PRID_VALUE(PRID), .HWINT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .EXLClr    (EXLClr),
    .pc_in     (pc_in),
    .EXcode_in (EXcode_in),
    .delay_in  (delay_in),
    .HWInt     (HWInt),
    .DOut      (DOut),
    .EPC_out   (EPC_out),
    .req       (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain every expectation queued for this cycle at the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.sel)
        0:       act = DOut;
        1:       act = EPC_out;
        default: act = {31'd0, req};
      endcase
      checks++;
      if (act !== c.exp) begin
        fails++;
        $display("FAIL %s: got %08h expected %08h", c.nm, act, c.exp);
      end
    end
  end

  task automatic chk(input int sel, input logic [31:0] v, input string nm);
    chk_t c;
    c.sel = sel;
    c.exp = v;
    c.nm  = nm;
    q.push_back(c);
  endtask

  // Advance to just after the next rising edge with quiescent controls
  task automatic cyc();
    @(posedge clk);
    #1;
    WE        = 1'b0;
    EXLClr    = 1'b0;
    EXcode_in = 5'd0;
    delay_in  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; A1 = 5'd15; A2 = 5'd0; DIn = '0; WE = 1'b0; EXLClr = 1'b0;
    pc_in = '0; EXcode_in = 5'd0; delay_in = 1'b0; HWInt = 6'd0;

    // 1: reset state
    #1;
    chk(0, PRID, "reset_prid");
    chk(1, 32'h0, "reset_epc_out");
    chk(2, 32'h0, "reset_req");
    @(negedge clk); #2;
    reset = 1'b1;
    cyc(); A1 = 5'd12; chk(0, 32'h0, "reset_sr");
    cyc(); A1 = 5'd13; chk(0, 32'h0, "reset_cause");
    cyc(); A1 = 5'd14; chk(0, 32'h0, "reset_epc");
    cyc(); A1 = 5'd0;  chk(0, 32'h0, "unmapped_read");

    // 2: enable IM[10]/IE and take a hardware interrupt
    cyc(); WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401; chk(2, 32'h0, "mtc0_sr_noreq");
    cyc(); A1 = 5'd12; chk(0, 32'h0000_0401, "sr_written");
    cyc(); HWInt = 6'b000001; pc_in = 32'h0000_1000; A1 = 5'd13;
    chk(2, 32'h1, "int_req_same_cycle");
    chk(0, 32'h0, "cause_ip_not_yet");
    cyc(); HWInt = 6'd0; A1 = 5'd13;
    chk(0, 32'h0000_0400, "int_cause");
    chk(1, 32'h0000_1000, "int_epc");
    chk(2, 32'h0, "exl_blocks_req");
    cyc(); A1 = 5'd12; chk(0, 32'h0000_0403, "int_sr_exl");
    cyc(); EXLClr = 1'b1;
    cyc(); A1 = 5'd12; chk(0, 32'h0000_0401, "eret_clears_exl");

    // 3: overflow in a delay slot
    cyc(); EXcode_in = 5'd12; delay_in = 1'b1; pc_in = 32'h0000_3010;
    chk(2, 32'h1, "ov_req");
    cyc(); A1 = 5'd13;
    chk(0, 32'h8000_0030, "ov_cause_bd");
    chk(1, 32'h0000_300C, "ov_epc_bd");
    cyc(); A1 = 5'd14; EXLClr = 1'b1; chk(0, 32'h0000_300C, "ov_epc_read");
    cyc(); A1 = 5'd12; chk(0, 32'h0000_0401, "ov_eret");

    // 4: interrupt beats exception; mtc0 SR dropped under req
    cyc(); HWInt = 6'b000001; EXcode_in = 5'd4; pc_in = 32'h0000_2000;
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
    chk(2, 32'h1, "int_vs_adel_req");
    cyc(); HWInt = 6'd0; A1 = 5'd13;
    chk(0, 32'h0000_0400, "int_priority_code");
    chk(1, 32'h0000_2000, "int_priority_epc");
    cyc(); A1 = 5'd12; chk(0, 32'h0000_0403, "we_dropped_on_req");

    // 5: one-deep handling, eret then pending exception re-raises
    cyc(); EXcode_in = 5'd10; chk(2, 32'h0, "ri_blocked_by_exl");
    cyc(); EXcode_in = 5'd10; EXLClr = 1'b1; chk(2, 32'h0, "ri_blocked_eret_cycle");
    cyc(); EXcode_in = 5'd10; EXLClr = 1'b1; pc_in = 32'h0000_4000; A1 = 5'd12;
    chk(0, 32'h0000_0401, "exl_cleared");
    chk(2, 32'h1, "ri_req_after_eret");
    cyc(); A1 = 5'd13;
    chk(0, 32'h0000_0028, "ri_cause");
    chk(1, 32'h0000_4000, "ri_epc");
    cyc(); A1 = 5'd12; chk(0, 32'h0000_0403, "req_beats_eret");
    cyc(); EXLClr = 1'b1;
    cyc(); WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF; EXLClr = 1'b1;
    cyc(); A1 = 5'd12; chk(0, 32'h0000_FC01, "sr_mask_then_eret");

    // 6: mtc0 EPC alignment and forwarding
    cyc(); WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3003;
`ifdef CP0_EPC_FWD_EN
    chk(1, 32'h0000_3000, "epc_fwd_same_cycle");
`else
    chk(1, 32'h0000_4000, "epc_no_fwd");
`endif
    cyc(); A1 = 5'd14;
    chk(0, 32'h0000_3000, "epc_aligned");
    chk(1, 32'h0000_3000, "epc_out_next");
    cyc(); WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    cyc(); A1 = 5'd13; chk(0, 32'h0000_0028, "cause_read_only");
    cyc(); WE = 1'b1; A2 = 5'd15; DIn = 32'h0;
    cyc(); A1 = 5'd15; chk(0, PRID, "prid_read_only");

    // pc - 4 wrap in a delay slot
    cyc(); EXcode_in = 5'd5; delay_in = 1'b1; pc_in = 32'h0000_0002;
    chk(2, 32'h1, "ades_req");
    cyc(); A1 = 5'd13;
    chk(0, 32'h8000_0014, "ades_cause");
    chk(1, 32'hFFFF_FFFC, "epc_wrap");

    // async reset while EXL=1
    cyc(); A1 = 5'd12;
    #1 reset = 1'b0;
    chk(0, 32'h0, "async_reset_sr");
    chk(1, 32'h0, "async_reset_epc");
    @(negedge clk); #1;
    reset = 1'b1;

    @(negedge clk); #1;
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
